// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between N_REQ requesters.
// Latency: one arbitration cycle per grant, then one beat per cycle (k-beat burst = k+1 cycles).
// Backpressure: FULL holds the grant and the beat count, and drops READY and W_INC for that cycle.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int N_REQ      = 4,
    parameter int MAX_BURST  = 8,
    parameter int ID_W       = 2
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [N_REQ-1:0]              REQ_VALID,
    input  logic [N_REQ-1:0]              REQ_LAST,
    input  logic [N_REQ*DATA_WIDTH-1:0]   REQ_DATA,
    output logic [N_REQ-1:0]              REQ_READY,
    input  logic                          FULL,
    output logic [DATA_WIDTH-1:0]         WR_DATA,
    output logic                          W_INC,
    output logic [ID_W-1:0]               GNT_ID,
    output logic                          BUSY
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam int SUM_W = ID_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
    localparam logic [SUM_W-1:0] N_REQ_W  = SUM_W'(N_REQ);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [ID_W-1:0]       rr_ptr, rr_ptr_nxt;
    logic [ID_W-1:0]       gnt_id, gnt_id_nxt;
    logic [CNT_W-1:0]      beat_cnt, beat_cnt_nxt;

    logic [2*N_REQ-1:0]    rot_valid;
    logic [SUM_W-1:0]      pick_sum;
    logic [ID_W-1:0]       pick_id;
    logic                  pick_vld;

    logic [SUM_W-1:0]      inc_sum;
    logic [ID_W-1:0]       gnt_next_ptr;

    logic [N_REQ-1:0]      gnt_onehot;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic                  gnt_valid;
    logic                  gnt_last;

    // Rotate the valid vector so bit 0 is rr_ptr, take the first set bit, map back to an index.
    always_comb begin
        rot_valid = {REQ_VALID, REQ_VALID} >> rr_ptr;
        pick_vld  = 1'b0;
        pick_sum  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!pick_vld && rot_valid[k]) begin
                pick_vld = 1'b1;
                pick_sum = {1'b0, rr_ptr} + SUM_W'(k);
            end
        end
        pick_id = (pick_sum >= N_REQ_W) ? ID_W'(pick_sum - N_REQ_W) : ID_W'(pick_sum);
    end

    // Steer the current owner's handshake and data; other requesters are masked out entirely.
    always_comb begin
        gnt_onehot = '0;
        gnt_data   = '0;
        gnt_valid  = 1'b0;
        gnt_last   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_id == ID_W'(i)) begin
                gnt_onehot[i] = 1'b1;
                gnt_data      = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
                gnt_valid     = REQ_VALID[i];
                gnt_last      = REQ_LAST[i];
            end
        end
        inc_sum      = {1'b0, gnt_id} + SUM_W'(1);
        gnt_next_ptr = (inc_sum >= N_REQ_W) ? ID_W'(inc_sum - N_REQ_W) : ID_W'(inc_sum);
    end

    // Next-state and write-port outputs; a beat moves only when the owner is valid and FULL is low.
    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        gnt_id_nxt   = gnt_id;
        beat_cnt_nxt = beat_cnt;
        REQ_READY    = '0;
        W_INC        = 1'b0;
        WR_DATA      = '0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    gnt_id_nxt   = pick_id;
                    beat_cnt_nxt = '0;
                    state_nxt    = GRANT;
                end
            end
            GRANT: begin
                WR_DATA   = gnt_data;
                REQ_READY = gnt_onehot & {N_REQ{~FULL}};
                W_INC     = gnt_valid & ~FULL;
                if (W_INC) begin
                    if (gnt_last || (beat_cnt == LAST_CNT)) begin
                        state_nxt    = IDLE;
                        rr_ptr_nxt   = gnt_next_ptr;
                        beat_cnt_nxt = '0;
                    end else begin
                        beat_cnt_nxt = beat_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State registers; a reset mid-burst simply abandons the grant.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gnt_id   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            gnt_id   <= gnt_id_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    assign GNT_ID = gnt_id;
    assign BUSY   = (state == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for the round-robin FIFO write arbiter.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
// A write log captured on W_INC stands in for the FIFO read side.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        full;
    logic [7:0]  wr_data;
    logic        w_inc;
    logic [1:0]  gnt_id;
    logic        busy;

    int n_err;
    int n_chk;
    logic [7:0] wr_log[$];
    logic [7:0] exp5[4];

    fifo_wr_arbiter #(
        .DATA_WIDTH(8),
        .N_REQ(4),
        .MAX_BURST(8),
        .ID_W(2)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .REQ_VALID(req_valid),
        .REQ_LAST(req_last),
        .REQ_DATA(req_data),
        .REQ_READY(req_ready),
        .FULL(full),
        .WR_DATA(wr_data),
        .W_INC(w_inc),
        .GNT_ID(gnt_id),
        .BUSY(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every written beat, as the FIFO would store it.
    always @(negedge clk) begin
        if (w_inc === 1'b1) wr_log.push_back(wr_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_post();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input int i, input logic [7:0] v);
        req_data[8*i +: 8] = v;
    endtask

    initial begin
        n_err     = 0;
        n_chk     = 0;
        rst       = 1'b1;
        req_valid = 4'hF;
        req_last  = 4'h0;
        req_data  = 32'h0;
        full      = 1'b0;
        exp5      = '{8'h51, 8'h52, 8'h53, 8'h54};

        // 1. Reset with every requester valid
        to_post();
        to_post();
        to_neg();
        chk("rst_w_inc", w_inc, 1'b0);
        chk("rst_ready", req_ready, 4'h0);
        chk("rst_gnt_id", gnt_id, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr_data", wr_data, 8'h00);
        to_post();
        rst       = 1'b0;
        req_valid = 4'h0;
        to_post();

        // 2. Single requester, 3-beat burst from req1
        req_valid = 4'b0010;
        set_d(1, 8'hA1);
        to_neg();
        chk("t2_arb_w_inc", w_inc, 1'b0);
        chk("t2_arb_busy", busy, 1'b0);
        to_post();
        to_neg();
        chk("t2_gnt_id", gnt_id, 2'd1);
        chk("t2_busy", busy, 1'b1);
        chk("t2_ready", req_ready, 4'b0010);
        chk("t2_b1_w_inc", w_inc, 1'b1);
        chk("t2_b1_data", wr_data, 8'hA1);
        to_post();
        set_d(1, 8'hA2);
        to_neg();
        chk("t2_b2_w_inc", w_inc, 1'b1);
        chk("t2_b2_data", wr_data, 8'hA2);
        to_post();
        set_d(1, 8'hA3);
        req_last = 4'b0010;
        to_neg();
        chk("t2_b3_w_inc", w_inc, 1'b1);
        chk("t2_b3_data", wr_data, 8'hA3);
        to_post();
        req_valid = 4'h0;
        req_last  = 4'h0;
        to_neg();
        chk("t2_idle_busy", busy, 1'b0);
        chk("t2_idle_w_inc", w_inc, 1'b0);
        to_post();

        // 2b. rr_ptr should now be 2: with req1 and req3 valid, req3 wins
        req_valid = 4'b1010;
        req_last  = 4'b1010;
        set_d(1, 8'h1B);
        set_d(3, 8'h3B);
        to_post();
        to_neg();
        chk("t2b_gnt_id", gnt_id, 2'd3);
        chk("t2b_ready", req_ready, 4'b1000);
        chk("t2b_data", wr_data, 8'h3B);
        chk("t2b_w_inc", w_inc, 1'b1);
        to_post();
        req_valid = 4'h0;
        req_last  = 4'h0;

        // 3. All valid, single-beat bursts: order 0,1,2,3,0
        req_valid = 4'hF;
        req_last  = 4'hF;
        for (int i = 0; i < 4; i++) set_d(i, 8'hC0 + 8'(i));
        for (int k = 0; k < 5; k++) begin
            to_neg();
            chk("t3_arb_w_inc", w_inc, 1'b0);
            to_post();
            to_neg();
            chk("t3_gnt_id", gnt_id, 32'(k % 4));
            chk("t3_w_inc", w_inc, 1'b1);
            chk("t3_data", wr_data, 32'(8'hC0 + 8'(k % 4)));
            to_post();
        end
        req_valid = 4'h0;
        req_last  = 4'h0;

        // 4. Burst cap: req0 streams 12 beats, req2 joins mid-burst
        req_valid = 4'b0001;
        set_d(0, 8'h41);
        to_post();
        req_valid = 4'b0101;
        req_last  = 4'b0100;
        set_d(2, 8'h2F);
        for (int n = 1; n <= 8; n++) begin
            set_d(0, 8'h40 + 8'(n));
            to_neg();
            chk("t4_gnt_id", gnt_id, 2'd0);
            chk("t4_w_inc", w_inc, 1'b1);
            chk("t4_data", wr_data, 32'(8'h40 + 8'(n)));
            to_post();
        end
        set_d(0, 8'h49);
        to_neg();
        chk("t4_cap_busy", busy, 1'b0);
        to_post();
        to_neg();
        chk("t4_req2_gnt", gnt_id, 2'd2);
        chk("t4_req2_data", wr_data, 8'h2F);
        chk("t4_req2_ready", req_ready, 4'b0100);
        to_post();
        req_valid = 4'b0001;
        req_last  = 4'b0000;
        to_post();
        for (int n = 9; n <= 12; n++) begin
            set_d(0, 8'h40 + 8'(n));
            if (n == 12) req_last = 4'b0001;
            to_neg();
            chk("t4_resume_gnt", gnt_id, 2'd0);
            chk("t4_resume_data", wr_data, 32'(8'h40 + 8'(n)));
            to_post();
        end
        req_valid = 4'h0;
        req_last  = 4'h0;

        // 5. Backpressure: FULL for 3 cycles after beat 2 of req1's burst
        wr_log.delete();
        req_valid = 4'b0010;
        set_d(1, 8'h51);
        to_post();
        to_neg();
        chk("t5_gnt_id", gnt_id, 2'd1);
        to_post();
        set_d(1, 8'h52);
        to_post();
        full = 1'b1;
        req_last = 4'b0010;
        set_d(1, 8'h53);
        for (int c = 0; c < 3; c++) begin
            to_neg();
            chk("t5_full_w_inc", w_inc, 1'b0);
            chk("t5_full_ready", req_ready, 4'b0000);
            chk("t5_full_busy", busy, 1'b1);
            to_post();
        end
        full     = 1'b0;
        req_last = 4'b0000;
        to_neg();
        chk("t5_b3_w_inc", w_inc, 1'b1);
        chk("t5_b3_data", wr_data, 8'h53);
        to_post();
        req_valid = 4'b0000;
        to_neg();
        chk("t5_gap_w_inc", w_inc, 1'b0);
        chk("t5_gap_busy", busy, 1'b1);
        to_post();
        req_valid = 4'b0010;
        req_last  = 4'b0010;
        set_d(1, 8'h54);
        to_post();
        req_valid = 4'h0;
        req_last  = 4'h0;
        to_neg();
        chk("t5_done_busy", busy, 1'b0);
        chk("t5_sb_count", wr_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < wr_log.size()) chk("t5_sb_data", wr_log[i], exp5[i]);
        end
        to_post();

        // 6. Reset mid-burst: req3 granted, reset after beat 2
        req_valid = 4'b1000;
        set_d(3, 8'h61);
        to_post();
        to_neg();
        chk("t6_gnt_id", gnt_id, 2'd3);
        to_post();
        set_d(3, 8'h62);
        to_post();
        rst = 1'b1;
        set_d(3, 8'h63);
        to_post();
        rst       = 1'b0;
        req_valid = 4'b1001;
        to_neg();
        chk("t6_busy", busy, 1'b0);
        chk("t6_w_inc", w_inc, 1'b0);
        chk("t6_gnt_rst", gnt_id, 2'd0);
        to_post();
        to_neg();
        chk("t6_favour_req0", gnt_id, 2'd0);
        chk("t6_favour_busy", busy, 1'b1);
        to_post();
        req_valid = 4'h0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
